adder_carry_select_iter: RTL and testbench

- Parametrised, multi-cycle carry-select adder for the datapath.
- Adds two p_nbits operands plus carry-in, one p_chunk-wide slice per cycle, starting at the least-significant slice.
- For each slice it computes two speculative slice sums, one for carry 0 and one for carry 1, then selects between them using the registered carry from the previous slice.
- Uses latency-insensitive val/rdy handshakes on input and output so it can sit between pipeline stages. It also adds a signed-overflow flag.

---
 rtl/adder_carry_select_iter.sv | 204 ++++++++++++++++++++
 tb/tb_adder_carry_select_iter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_carry_select_iter.sv
// adder_carry_select_iter
//
// Multi-cycle carry-select adder. The operands are captured once, then one
// p_chunk-wide slice is added per cycle, least-significant slice first. For
// every slice two speculative sums are formed (carry-in 0 and carry-in 1)
// and the registered carry from the previous slice picks one of them.
// A signed-overflow flag is produced alongside the carry out.
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   rst      in   synchronous, active-high reset
//   in_val   in   operands valid
//   in_rdy   out  block can accept operands (IDLE only)
//   in0      in   operand A, p_nbits
//   in1      in   operand B, p_nbits
//   cin      in   carry-in
//   out_val  out  result valid (DONE only)
//   out_rdy  in   consumer accepts the result
//   sum      out  in0 + in1 + cin modulo 2^p_nbits
//   cout     out  carry out of the MSB
//   ovf      out  signed overflow
//
// Handshake: a transfer happens on a rising edge where val and rdy are both
// 1. rdy is decoded from the FSM state only, so it never depends on val in
// the same cycle. A producer that raises val keeps it (and its data) until
// the transfer; a result stays stable while out_val && !out_rdy.
//
// p_nbits must be a non-zero multiple of p_chunk.

module adder_carry_select_iter #(
    parameter int p_nbits = 32,
    parameter int p_chunk = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic               cin,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] sum,
    output logic               cout,
    output logic               ovf
);

    localparam int c_nslices = p_nbits / p_chunk;
    localparam int c_idx_w   = (c_nslices > 1) ? $clog2(c_nslices) : 1;
    localparam int c_msb     = p_nbits - 1;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_calc = 2'd1,
        st_done = 2'd2
    } state_t;

    // Complete control state (phase plus slice index) in one bundle so that
    // checkers can observe the whole FSM through a single signal.
    typedef struct packed {
        state_t             state;
        logic [c_idx_w-1:0] idx;
    } fsm_t;

    fsm_t fsm_q;
    fsm_t fsm_d;

    // Captured operands and result registers
    logic [p_nbits-1:0] a_q;
    logic [p_nbits-1:0] b_q;
    logic [p_nbits-1:0] sum_q;
    logic               carry_q;
    logic               cout_q;
    logic               ovf_q;

    // Slice datapath
    int                 slice_lo;
    logic [p_chunk-1:0] a_sl;
    logic [p_chunk-1:0] b_sl;
    logic [p_chunk:0]   s0;
    logic [p_chunk:0]   s1;
    logic [p_chunk:0]   sel;
    logic [p_nbits-1:0] sum_nxt;
    logic               ovf_nxt;
    logic               last_slice;

    assign last_slice = (fsm_q.idx == c_idx_w'(c_nslices - 1));

    // Both speculative sums are formed from the captured operands; the
    // carry register only drives the final select.
    always_comb begin
        slice_lo = int'(fsm_q.idx) * p_chunk;
        a_sl     = a_q[slice_lo +: p_chunk];
        b_sl     = b_q[slice_lo +: p_chunk];
        s0       = {1'b0, a_sl} + {1'b0, b_sl};
        s1       = {1'b0, a_sl} + {1'b0, b_sl} + (p_chunk + 1)'(1);
        sel      = carry_q ? s1 : s0;
        sum_nxt  = sum_q;
        sum_nxt[slice_lo +: p_chunk] = sel[p_chunk-1:0];
        // Evaluated on the slice that writes the MSB, so it sees the new MSB
        ovf_nxt  = (a_q[c_msb] == b_q[c_msb]) && (sum_nxt[c_msb] != a_q[c_msb]);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q.state <= st_idle;
            fsm_q.idx   <= '0;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q.state)
            st_idle: begin
                if (in_val) begin
                    fsm_d.state = st_calc;
                    fsm_d.idx   = '0;
                end
            end
            st_calc: begin
                if (last_slice) begin
                    fsm_d.state = st_done;
                end else begin
                    fsm_d.idx = fsm_q.idx + c_idx_w'(1);
                end
            end
            st_done: begin
                if (out_rdy) begin
                    fsm_d.state = st_idle;
                end
            end
            default: begin
                fsm_d.state = st_idle;
                fsm_d.idx   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (state decode only)
    // ------------------------------------------------------------------
    always_comb begin
        in_rdy  = 1'b0;
        out_val = 1'b0;
        case (fsm_q.state)
            st_idle: in_rdy  = 1'b1;
            st_done: out_val = 1'b1;
            default: begin
                in_rdy  = 1'b0;
                out_val = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (fsm_q.state)
                st_idle: begin
                    // in_rdy is 1 throughout IDLE, so in_val alone marks a transfer
                    if (in_val) begin
                        a_q     <= in0;
                        b_q     <= in1;
                        carry_q <= cin;
                    end
                end
                st_calc: begin
                    sum_q   <= sum_nxt;
                    carry_q <= sel[p_chunk];
                    if (last_slice) begin
                        cout_q <= sel[p_chunk];
                        ovf_q  <= ovf_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers are never touched in DONE or IDLE, so the last result
    // holds through backpressure and afterwards.
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_carry_select_iter.sv
// Directed bench for adder_carry_select_iter: a 32/8 instance for the main
// cases plus 8/4 and 8/8 instances for small-parameter behaviour.

module tb_adder_carry_select_iter;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------
    logic        in_val, in_rdy, cin, out_val, out_rdy, cout, ovf;
    logic [31:0] in0, in1, sum;

    adder_carry_select_iter #(.p_nbits(32), .p_chunk(8)) dut (
        .clk(clk), .rst(rst),
        .in_val(in_val), .in_rdy(in_rdy),
        .in0(in0), .in1(in1), .cin(cin),
        .out_val(out_val), .out_rdy(out_rdy),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Shared stimulus for the two 8-bit instances
    logic       s_in_val, s_cin, s_out_rdy;
    logic [7:0] s_in0, s_in1;

    logic       a_in_rdy, a_out_val, a_cout, a_ovf;
    logic [7:0] a_sum;
    logic       b_in_rdy, b_out_val, b_cout, b_ovf;
    logic [7:0] b_sum;

    adder_carry_select_iter #(.p_nbits(8), .p_chunk(4)) dut_8x4 (
        .clk(clk), .rst(rst),
        .in_val(s_in_val), .in_rdy(a_in_rdy),
        .in0(s_in0), .in1(s_in1), .cin(s_cin),
        .out_val(a_out_val), .out_rdy(s_out_rdy),
        .sum(a_sum), .cout(a_cout), .ovf(a_ovf)
    );

    adder_carry_select_iter #(.p_nbits(8), .p_chunk(8)) dut_8x8 (
        .clk(clk), .rst(rst),
        .in_val(s_in_val), .in_rdy(b_in_rdy),
        .in0(s_in0), .in1(s_in1), .cin(s_cin),
        .out_val(b_out_val), .out_rdy(s_out_rdy),
        .sum(b_sum), .cout(b_cout), .ovf(b_ovf)
    );

    // ------------------------------------------------------------------
    // Scoreboard: {cout, ovf, sum} per accepted operation
    // ------------------------------------------------------------------
    logic [33:0] exp_q[$];
    int          n_total;
    int          n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: one operation on the 32-bit instance. Called at a negedge.
    // hold = number of extra DONE cycles with out_rdy low.
    // ------------------------------------------------------------------
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic [31:0] es, input logic ec, input logic eo,
                         input int hold);
        int          lat;
        logic [33:0] e;
        check("pre_in_rdy", {63'd0, in_rdy}, 64'd1);
        exp_q.push_back({ec, eo, es});
        in0     = a;
        in1     = b;
        cin     = c;
        in_val  = 1'b1;
        out_rdy = (hold == 0);
        lat     = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // Operands were captured; scramble them to prove it
                in_val = 1'b0;
                in0    = ~a;
                in1    = ~b;
                cin    = ~c;
            end
        end while (!out_val && lat < 40);
        check("latency", 64'(lat), 64'd5);
        e = exp_q.pop_front();
        check("sum",  {32'd0, sum},  {32'd0, e[31:0]});
        check("cout", {63'd0, cout}, {63'd0, e[33]});
        check("ovf",  {63'd0, ovf},  {63'd0, e[32]});
        for (int k = 0; k < hold; k++) begin
            in0    = a ^ (32'h5A5A_A5A5 << k);
            in1    = b + 32'(k + 1);
            in_val = 1'b1;
            @(negedge clk);
            check("hold_out_val", {63'd0, out_val}, 64'd1);
            check("hold_in_rdy",  {63'd0, in_rdy},  64'd0);
            check("hold_sum",  {32'd0, sum},  {32'd0, e[31:0]});
            check("hold_cout", {63'd0, cout}, {63'd0, e[33]});
            check("hold_ovf",  {63'd0, ovf},  {63'd0, e[32]});
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        check("back_in_rdy",  {63'd0, in_rdy},  64'd1);
        check("back_out_val", {63'd0, out_val}, 64'd0);
        check("idle_sum_kept", {32'd0, sum}, {32'd0, e[31:0]});
    endtask

    // ------------------------------------------------------------------
    // Driver: one operation on both 8-bit instances. Called at a negedge.
    // ------------------------------------------------------------------
    task automatic do_small(input logic [7:0] a, input logic [7:0] b, input logic c,
                            input logic [7:0] es, input logic ec, input logic eo);
        int          lat, lat_a, lat_b;
        logic [9:0]  got_a, got_b;
        logic [33:0] e;
        check("s_pre_rdy", {62'd0, a_in_rdy, b_in_rdy}, 64'd3);
        exp_q.push_back({ec, eo, 24'd0, es});
        s_in0     = a;
        s_in1     = b;
        s_cin     = c;
        s_in_val  = 1'b1;
        s_out_rdy = 1'b1;
        lat   = 0;
        lat_a = 0;
        lat_b = 0;
        got_a = '0;
        got_b = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                s_in_val = 1'b0;
                s_in0    = ~a;
                s_in1    = ~b;
                s_cin    = ~c;
            end
            if (a_out_val && lat_a == 0) begin
                lat_a = lat;
                got_a = {a_cout, a_ovf, a_sum};
            end
            if (b_out_val && lat_b == 0) begin
                lat_b = lat;
                got_b = {b_cout, b_ovf, b_sum};
            end
        end while ((lat_a == 0 || lat_b == 0) && lat < 40);
        e = exp_q.pop_front();
        check("lat_8x4", 64'(lat_a), 64'd3);
        check("lat_8x8", 64'(lat_b), 64'd2);
        check("res_8x4", {54'd0, got_a}, {54'd0, e[33], e[32], e[7:0]});
        check("res_8x8", {54'd0, got_b}, {54'd0, e[33], e[32], e[7:0]});
        @(negedge clk);
        check("s_back_rdy", {62'd0, a_in_rdy, b_in_rdy}, 64'd3);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_val    = 1'b0;
        in0       = '0;
        in1       = '0;
        cin       = 1'b0;
        out_rdy   = 1'b1;
        s_in_val  = 1'b0;
        s_in0     = '0;
        s_in1     = '0;
        s_cin     = 1'b0;
        s_out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_in_rdy",  {63'd0, in_rdy},  64'd1);
        check("rst_out_val", {63'd0, out_val}, 64'd0);
        check("rst_sum",  {32'd0, sum}, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        check("rst_ovf",  {63'd0, ovf},  64'd0);

        // Carry ripples through every slice
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
        // Positive + positive overflow
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
        // Carry-in used
        do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 0);
        // Backpressure, negative + negative overflow with carry out
        do_op(32'h9ABC_DEF0, 32'h8765_4321, 1'b0, 32'h2222_2211, 1'b1, 1'b1, 3);

        // Reset abort in the second CALC cycle
        check("abort_pre_rdy", {63'd0, in_rdy}, 64'd1);
        in0    = 32'h0F0F_0F0F;
        in1    = 32'h0101_0101;
        cin    = 1'b0;
        in_val = 1'b1;
        @(negedge clk);
        in_val = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_rdy",  {63'd0, in_rdy},  64'd1);
        check("abort_out_val", {63'd0, out_val}, 64'd0);
        check("abort_sum",  {32'd0, sum}, 64'd0);
        check("abort_cout", {63'd0, cout}, 64'd0);
        check("abort_ovf",  {63'd0, ovf},  64'd0);
        do_op(32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 0);

        // Small parameter sets
        do_small(8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
        do_small(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_small(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
